// File: rtl/gsensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gsensor_ctrl
// Purpose  : ADXL345 sequencer/arbiter in front of the 16-bit spi_serdes:
//            init writes, periodic X/Y/Z burst reads, host register access.
// Revision : 1.0 - initial release
// ============================================================================
module gsensor_ctrl #(
    parameter logic [15:0] SAMPLE_DIV      = 16'd50000,
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08
) (
    input  logic        spi_clk,
    input  logic        reset_n,
    output logic [15:0] ser_data_tx,
    output logic        ser_start,
    input  logic        ser_done,
    input  logic [7:0]  ser_data_rx,
    input  logic        host_req,
    input  logic [15:0] host_tx,
    output logic        host_ack,
    output logic [7:0]  host_rx,
    output logic        init_done,
    output logic [15:0] data_x,
    output logic [15:0] data_y,
    output logic [15:0] data_z,
    output logic        data_valid
);

    localparam logic [2:0] c_INIT_ISSUE = 3'd0;
    localparam logic [2:0] c_INIT_WAIT  = 3'd1;
    localparam logic [2:0] c_GAP        = 3'd2;
    localparam logic [2:0] c_IDLE       = 3'd3;
    localparam logic [2:0] c_HOST_ISSUE = 3'd4;
    localparam logic [2:0] c_HOST_WAIT  = 3'd5;
    localparam logic [2:0] c_RD_ISSUE   = 3'd6;
    localparam logic [2:0] c_RD_WAIT    = 3'd7;

    localparam logic [5:0] c_BW_RATE_ADDR     = 6'h2C;
    localparam logic [5:0] c_DATA_FORMAT_ADDR = 6'h31;
    localparam logic [5:0] c_POWER_CTL_ADDR   = 6'h2D;
    localparam logic [5:0] c_DATAX0_ADDR      = 6'h32;
    localparam logic [2:0] c_LAST_BYTE        = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_ser_start;
    logic [15:0] r_ser_data_tx;
    logic [1:0]  r_step;
    logic [2:0]  r_byte_idx;
    logic        r_in_burst;
    logic [39:0] r_shadow;
    logic [15:0] r_tick_cnt;
    logic        r_sample_pend;
    logic        r_init_done;
    logic [7:0]  r_host_rx;
    logic [15:0] r_data_x;
    logic [15:0] r_data_y;
    logic [15:0] r_data_z;
    logic        r_data_valid;

    logic        w_issue;
    logic [15:0] w_tx_word;
    logic [2:0]  w_rd_idx;
    logic        w_burst_start;
    logic        w_tick_wrap;
    logic        w_host_ack;

    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_INIT_ISSUE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ISSUE states are left only once their start pulse has been driven, so
    // the post-reset INIT_ISSUE (entered with ser_start low) still issues.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_INIT_ISSUE: if (r_ser_start) w_next_state = c_INIT_WAIT;
            c_INIT_WAIT:  if (ser_done)    w_next_state = c_GAP;
            c_GAP: begin
                if (!r_init_done)    w_next_state = c_INIT_ISSUE;
                else if (r_in_burst) w_next_state = c_RD_ISSUE;
                else                 w_next_state = c_IDLE;
            end
            c_IDLE: begin
                if (r_init_done) begin
                    if (host_req)           w_next_state = c_HOST_ISSUE;
                    else if (r_sample_pend) w_next_state = c_RD_ISSUE;
                end
            end
            c_HOST_ISSUE: if (r_ser_start) w_next_state = c_HOST_WAIT;
            c_HOST_WAIT:  if (ser_done)    w_next_state = c_GAP;
            c_RD_ISSUE:   if (r_ser_start) w_next_state = c_RD_WAIT;
            c_RD_WAIT:    if (ser_done)    w_next_state = c_GAP;
            default:      w_next_state = c_INIT_ISSUE;
        endcase
    end

    always_comb begin
        w_issue       = 1'b0;
        w_tx_word     = r_ser_data_tx;
        w_rd_idx      = (r_state == c_IDLE) ? 3'd0 : r_byte_idx;
        w_burst_start = (r_state == c_IDLE) && (w_next_state == c_RD_ISSUE);
        w_host_ack    = (r_state == c_HOST_WAIT) && ser_done;
        case (w_next_state)
            c_INIT_ISSUE: begin
                w_issue = !r_ser_start;
                case (r_step)
                    2'd0:    w_tx_word = {2'b00, c_BW_RATE_ADDR, BW_RATE_VAL};
                    2'd1:    w_tx_word = {2'b00, c_DATA_FORMAT_ADDR, DATA_FORMAT_VAL};
                    default: w_tx_word = {2'b00, c_POWER_CTL_ADDR, POWER_CTL_VAL};
                endcase
            end
            c_HOST_ISSUE: begin
                w_issue   = !r_ser_start;
                w_tx_word = host_tx;
            end
            c_RD_ISSUE: begin
                w_issue   = !r_ser_start;
                w_tx_word = {2'b10, c_DATAX0_ADDR + {3'b000, w_rd_idx}, 8'h00};
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
    end

    assign w_tick_wrap = (r_tick_cnt == SAMPLE_DIV - 16'd1);

    always_ff @(posedge spi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ser_start   <= 1'b0;
            r_ser_data_tx <= 16'h0000;
            r_step        <= 2'd0;
            r_byte_idx    <= 3'd0;
            r_in_burst    <= 1'b0;
            r_shadow      <= 40'h0;
            r_tick_cnt    <= 16'h0000;
            r_sample_pend <= 1'b0;
            r_init_done   <= 1'b0;
            r_host_rx     <= 8'h00;
            r_data_x      <= 16'h0000;
            r_data_y      <= 16'h0000;
            r_data_z      <= 16'h0000;
            r_data_valid  <= 1'b0;
        end else begin
            r_ser_start  <= w_issue;
            r_data_valid <= 1'b0;
            if (w_issue) begin
                r_ser_data_tx <= w_tx_word;
            end

            r_tick_cnt <= w_tick_wrap ? 16'h0000 : r_tick_cnt + 16'd1;
            // A tick landing on the burst-start cycle belongs to the next burst.
            if (w_burst_start) begin
                r_sample_pend <= 1'b0;
                r_in_burst    <= 1'b1;
                r_byte_idx    <= 3'd0;
            end
            if (w_tick_wrap) begin
                r_sample_pend <= 1'b1;
            end

            if ((r_state == c_INIT_WAIT) && ser_done) begin
                r_step <= r_step + 2'd1;
                if (r_step == 2'd2) begin
                    r_init_done <= 1'b1;
                end
            end

            if (w_host_ack && r_ser_data_tx[15]) begin
                r_host_rx <= ser_data_rx;
            end

            if ((r_state == c_RD_WAIT) && ser_done) begin
                r_byte_idx <= r_byte_idx + 3'd1;
                if (r_byte_idx == c_LAST_BYTE) begin
                    r_data_x     <= {r_shadow[15:8], r_shadow[7:0]};
                    r_data_y     <= {r_shadow[31:24], r_shadow[23:16]};
                    r_data_z     <= {ser_data_rx, r_shadow[39:32]};
                    r_data_valid <= 1'b1;
                    r_in_burst   <= 1'b0;
                end else begin
                    r_shadow <= {ser_data_rx, r_shadow[39:8]};
                end
            end
        end
    end

    assign ser_start   = r_ser_start;
    assign ser_data_tx = r_ser_data_tx;
    assign host_ack    = w_host_ack;
    assign host_rx     = r_host_rx;
    assign init_done   = r_init_done;
    assign data_x      = r_data_x;
    assign data_y      = r_data_y;
    assign data_z      = r_data_z;
    assign data_valid  = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_gsensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsensor_ctrl
// Purpose  : Self-checking bench for gsensor_ctrl with a behavioural serdes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsensor_ctrl;

    localparam int c_DIV = 300;
    localparam int c_LAT = 20;

    logic        spi_clk = 1'b0;
    logic        reset_n;
    logic [15:0] ser_data_tx;
    logic        ser_start;
    logic        ser_done = 1'b0;
    logic [7:0]  ser_data_rx = 8'h00;
    logic        host_req;
    logic [15:0] host_tx;
    logic        host_ack;
    logic [7:0]  host_rx;
    logic        init_done;
    logic [15:0] data_x;
    logic [15:0] data_y;
    logic [15:0] data_z;
    logic        data_valid;

    gsensor_ctrl #(
        .SAMPLE_DIV(16'd300)
    ) dut (
        .spi_clk(spi_clk), .reset_n(reset_n),
        .ser_data_tx(ser_data_tx), .ser_start(ser_start),
        .ser_done(ser_done), .ser_data_rx(ser_data_rx),
        .host_req(host_req), .host_tx(host_tx),
        .host_ack(host_ack), .host_rx(host_rx),
        .init_done(init_done),
        .data_x(data_x), .data_y(data_y), .data_z(data_z),
        .data_valid(data_valid)
    );

    always #5 spi_clk = ~spi_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural serdes and tick reference ----------------
    logic [15:0] sw[$];
    logic [7:0]  cur_bytes[6];
    logic [15:0] hold;
    bit          busy = 0;
    bit          fixed_first = 1;
    bit          slow_req = 0;
    int          cyc = 0;
    int          last_done = -10;
    int          done_at = 0;
    int          slow_tick = 0;
    int          n_b200 = 0;

    function automatic logic [7:0] resp(input logic [15:0] w);
        int a;
        a = int'(w[13:8]);
        if (!w[15]) return 8'($urandom);
        if (a == 0) return 8'hE5;
        if (a >= 'h32 && a <= 'h37) return cur_bytes[a - 'h32];
        return 8'h00;
    endfunction

    always @(posedge spi_clk) begin
        #1;
        if (!reset_n) begin
            busy = 0; ser_done = 1'b0; ser_data_rx = 8'h00;
            cyc = 0; last_done = -10;
        end else begin
            cyc++;
            ser_done = 1'b0;
            if (ser_start) begin
                chk("start_while_busy", 64'(busy), 64'd0);
                chk("start_gap", 64'(cyc - last_done >= 2), 64'd1);
                sw.push_back(ser_data_tx);
                hold = ser_data_tx;
                busy = 1;
                done_at = cyc + c_LAT;
                if (ser_data_tx == 16'hB200) begin
                    n_b200++;
                    for (int i = 0; i < 6; i++)
                        cur_bytes[i] = fixed_first ? 8'(i + 1) : 8'($urandom);
                    fixed_first = 0;
                end
                if (ser_data_tx == 16'hB700 && slow_req) begin
                    // finish just after a tick, at least two tick periods away
                    slow_tick = ((cyc + 620) / c_DIV + 1) * c_DIV;
                    done_at = slow_tick + 10;
                    slow_req = 0;
                end
            end else if (busy) begin
                if (ser_data_tx !== hold) chk("tx_stable", 64'(ser_data_tx), 64'(hold));
                if (cyc == done_at) begin
                    ser_done = 1'b1;
                    ser_data_rx = resp(hold);
                    busy = 0;
                    last_done = cyc;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int          n_valid = 0;
    logic [47:0] prev_xyz = '0;
    logic        prev_init = 1'b0;

    always @(posedge spi_clk) begin
        #3;
        if (!reset_n) begin
            prev_xyz = '0; prev_init = 1'b0;
        end else begin
            if (data_valid) begin
                n_valid++;
                chk("mon_x", 64'(data_x), 64'({cur_bytes[1], cur_bytes[0]}));
                chk("mon_y", 64'(data_y), 64'({cur_bytes[3], cur_bytes[2]}));
                chk("mon_z", 64'(data_z), 64'({cur_bytes[5], cur_bytes[4]}));
            end else if ({data_x, data_y, data_z} !== prev_xyz) begin
                chk("xyz_change_no_valid", 64'({data_x, data_y, data_z}), 64'(prev_xyz));
            end
            if (prev_init && !init_done) chk("init_sticky", 64'(init_done), 64'd1);
            prev_xyz = {data_x, data_y, data_z};
            prev_init = init_done;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_init(input int bound);
        int n = 0;
        while (!init_done && n < bound) begin @(negedge spi_clk); n++; end
        chk("init_done_seen", 64'(init_done), 64'd1);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        do begin @(negedge spi_clk); n++; end while (!data_valid && n < bound);
        chk(tag, 64'(data_valid), 64'd1);
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int n = 0;
        do begin @(negedge spi_clk); n++; end while (!host_ack && n < bound);
        chk(tag, 64'(host_ack), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 64'(ser_start), 64'd0);
        chk({tag, "_tx"}, 64'(ser_data_tx), 64'd0);
        chk({tag, "_ack"}, 64'(host_ack), 64'd0);
        chk({tag, "_hrx"}, 64'(host_rx), 64'd0);
        chk({tag, "_init"}, 64'(init_done), 64'd0);
        chk({tag, "_xyz"}, 64'({data_x, data_y, data_z}), 64'd0);
        chk({tag, "_valid"}, 64'(data_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nv, nb, t, n;
        reset_n = 1'b0; host_req = 1'b0; host_tx = 16'h0000;
        repeat (3) @(negedge spi_clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // init sequence
        wait_init(300);
        chk("init_starts", 64'(sw.size()), 64'd3);
        chk("init_w0", 64'(sw[0]), 64'h2C0A);
        chk("init_w1", 64'(sw[1]), 64'h310B);
        chk("init_w2", 64'(sw[2]), 64'h2D08);
        chk("no_valid_in_init", 64'(n_valid), 64'd0);

        // first burst with bytes 01..06
        wait_valid("burst1_valid", 800);
        for (int i = 0; i < 6; i++)
            chk("burst1_word", 64'(sw[3 + i]), 64'({8'hB2 + 8'(i), 8'h00}));
        chk("burst1_x", 64'(data_x), 64'h0201);
        chk("burst1_y", 64'(data_y), 64'h0403);
        chk("burst1_z", 64'(data_z), 64'h0605);
        @(negedge spi_clk);
        chk("burst1_one_pulse", 64'(data_valid), 64'd0);
        chk("burst1_nvalid", 64'(n_valid), 64'd1);

        // host read raised while a burst is running
        n = 0;
        while (n_b200 < 2 && n < 800) begin @(negedge spi_clk); n++; end
        chk("burst2_started", 64'(n_b200), 64'd2);
        host_tx = 16'hC000; host_req = 1'b1;
        wait_ack("hread_ack", 800);
        host_req = 1'b0;
        chk("hread_word", 64'(sw[sw.size() - 1]), 64'hC000);
        chk("hread_after_b7", 64'(sw[sw.size() - 2]), 64'hB700);
        chk("hread_after_b2", 64'(sw[sw.size() - 7]), 64'hB200);
        @(negedge spi_clk);
        chk("hread_rx", 64'(host_rx), 64'hE5);
        chk("hread_ack_pulse", 64'(host_ack), 64'd0);

        // host write coinciding with a pending tick in IDLE
        t = ((cyc / c_DIV) + 1) * c_DIV;
        if (t - cyc < 40) t += c_DIV;
        while (cyc < t) @(negedge spi_clk);
        base = sw.size();
        host_tx = 16'h1E7F; host_req = 1'b1;
        wait_ack("hwrite_ack", 200);
        host_req = 1'b0;
        chk("hwrite_first", 64'(sw[base]), 64'h1E7F);
        wait_valid("hwrite_burst_valid", 400);
        for (int i = 0; i < 6; i++)
            chk("hwrite_burst_word", 64'(sw[base + 1 + i]), 64'({8'hB2 + 8'(i), 8'h00}));
        chk("hwrite_rx_kept", 64'(host_rx), 64'hE5);

        // slow burst spanning two ticks: exactly one catch-up burst
        slow_req = 1;
        wait_valid("slow_valid", 2000);
        nb = n_b200;
        nv = n_valid;
        n = 0;
        while (cyc < slow_tick + 290 && n < 1000) begin @(negedge spi_clk); n++; end
        chk("coalesce_bursts", 64'(n_b200 - nb), 64'd1);
        chk("coalesce_valids", 64'(n_valid - nv), 64'd1);

        // reset in the middle of a burst, after byte 3
        n = 0;
        while (!(sw.size() > 0 && sw[sw.size() - 1] == 16'hB600) && n < 800) begin
            @(negedge spi_clk); n++;
        end
        chk("midburst_reached", 64'(sw[sw.size() - 1]), 64'hB600);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        nv = n_valid;
        base = sw.size();
        repeat (2) @(negedge spi_clk);
        reset_n = 1'b1;
        wait_init(300);
        chk("reinit_w0", 64'(sw[base]), 64'h2C0A);
        chk("reinit_w1", 64'(sw[base + 1]), 64'h310B);
        chk("reinit_w2", 64'(sw[base + 2]), 64'h2D08);
        chk("reinit_no_valid", 64'(n_valid), 64'(nv));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gsensor_ctrl.md
Name: gsensor_ctrl

Overview:
Sequencer and arbiter for the 16-bit SPI serializer/deserializer (spi_serdes) driving the ADXL345 accelerometer.
- After reset, issues a fixed three-write init sequence.
- Then runs periodic six-byte axis-read bursts and presents coherent X/Y/Z samples.
- Shares the serdes with a single host register-access port, arbitrating only at burst boundaries.
- Sits between the application logic and spi_serdes, in the spi_clk domain.

Parameters:
SAMPLE_DIV, 16'd50000, spi_clk cycles between sample ticks (minimum 200)
BW_RATE_VAL, 8'h0A, value written to register 0x2C
DATA_FORMAT_VAL, 8'h0B, value written to register 0x31
POWER_CTL_VAL, 8'h08, value written to register 0x2D

Ports:
spi_clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous reset, active low
ser_data_tx  out  16  command word to serdes
ser_start  out  1  one-cycle start pulse to serdes
ser_done  in  1  serdes completion pulse
ser_data_rx  in  8  serdes read byte, valid while ser_done=1
host_req  in  1  host access request, level, held until ack
host_tx  in  16  host command word; bit15=1 means read
host_ack  out  1  one-cycle completion pulse
host_rx  out  8  host read data
init_done  out  1  init sequence complete (sticky)
data_x  out  16  {DATAX1,DATAX0}
data_y  out  16  {DATAY1,DATAY0}
data_z  out  16  {DATAZ1,DATAZ0}
data_valid  out  1  one-cycle pulse on new X/Y/Z

Behaviour:
- Reset (asynchronous, any state):
  - All outputs are 0.
  - FSM goes to INIT_ISSUE with step index 0.
  - Tick counter is 0; sample_pend is 0.
  - Reset during a transfer abandons it; no ack or valid is generated.
- Command words:
  - Write: {2'b00, addr[5:0], data[7:0]}.
  - Read: {1'b1, 1'b0, addr[5:0], 8'h00}.
  - The multibyte bit is always 0.
- Transaction rule (all requesters):
  - ser_start is registered and high for exactly 1 cycle, with ser_data_tx stable from that cycle until ser_done.
  - Only one transaction is outstanding at a time.
  - The next ser_start is asserted no earlier than the 2nd cycle after a ser_done cycle, because the serdes stalls one cycle.
  - ser_done is ignored in any state other than a WAIT state.
- FSM states:
  - INIT_ISSUE -> INIT_WAIT -> GAP.
    - Init steps: 0x2C←BW_RATE_VAL, 0x31←DATA_FORMAT_VAL, 0x2D←POWER_CTL_VAL.
    - After step 2 completes, init_done goes to 1 and stays 1 until reset.
  - IDLE arbitration (evaluated only when init_done=1):
    - host_req=1 has priority -> HOST_ISSUE.
    - Otherwise sample_pend=1 -> RD_ISSUE with byte index 0.
    - Otherwise stay in IDLE.
  - HOST_ISSUE -> HOST_WAIT.
    - ser_data_tx = host_tx, captured at issue.
    - On ser_done: host_ack=1 for 1 cycle.
    - If host_tx[15]=1, host_rx <= ser_data_rx in the same cycle; on writes host_rx is unchanged.
    - Then -> GAP -> IDLE.
    - The host must drop host_req in the cycle after host_ack, otherwise a new access starts.
  - RD_ISSUE -> RD_WAIT -> GAP, repeated for addresses 0x32..0x37 (byte index 0..5).
    - Bytes are stored in a shadow register.
    - A host request is not granted mid-burst.
    - After byte 5's ser_done, data_x/y/z all update in the same cycle, with data_valid=1 for that cycle.
    - Then GAP -> IDLE.
  - GAP lasts exactly 1 cycle.
- Sample tick:
  - A counter runs 0..SAMPLE_DIV-1 and wraps; at wrap it sets sample_pend.
  - sample_pend clears on entry to RD_ISSUE for byte 0.
  - Ticks arriving while a tick is already pending coalesce (no queue).
  - The counter runs during init, but sample_pend is not acted on until init_done=1.
  - A tick during a burst sets sample_pend for the next burst.
- Latency:
  - A host_req seen in IDLE gives ser_start on the next cycle.
  - host_ack comes in the ser_done cycle.

Test Plan:
- Reset, then run with a behavioural serdes (done 20 cycles after start) -> exactly 3 starts with words 16'h2C0A, 16'h310B, 16'h2D08; init_done=1 after the 3rd done; ≥1 idle cycle between done and the next start.
- Set SAMPLE_DIV=300 and have the model return bytes 01,02,03,04,05,06 -> read words 16'hB200..16'hB700 in order; data_x=16'h0201, data_y=16'h0403, data_z=16'h0605, one data_valid pulse; no output change before the 6th done.
- Raise host_req with host_tx=16'hC000 (read 0x00) while the model returns 8'hE5 and a burst is active -> start withheld until burst end; host_ack pulse with host_rx=8'hE5.
- Host write 16'h1E7F together with a pending tick in IDLE -> host transaction first, then the burst; host_rx unchanged.
- Hold a burst past two tick periods -> only one extra burst runs (coalescing).
- Assert reset_n=0 mid-burst, after byte 3 -> outputs go to 0 immediately; after release, the init sequence restarts from 16'h2C0A with no data_valid.
